// File: rtl/noc_local_injector.sv
// Local-port packet injector: turns a core message descriptor plus payload stream
// into head/body/tail flits on the lowest free virtual channel of the router.
module noc_local_injector #(
    parameter int CHANNELS = 2,
    parameter int FLIT_W   = 34,
    parameter int ID_X_W   = 4,
    parameter int ID_Y_W   = 4,
    parameter int LEN_W    = 4
) (
    input  logic                noc_clk,
    input  logic                noc_rst_n,
    input  logic [ID_X_W-1:0]   id_x,
    input  logic [ID_Y_W-1:0]   id_y,
    input  logic                msg_valid,
    output logic                msg_ready,
    input  logic [ID_X_W-1:0]   msg_dest_x,
    input  logic [ID_Y_W-1:0]   msg_dest_y,
    input  logic [LEN_W-1:0]    msg_len,
    input  logic                data_valid,
    output logic                data_ready,
    input  logic [FLIT_W-3:0]   data,
    output logic [CHANNELS-1:0] tx_valid,
    output logic [FLIT_W-1:0]   tx_flit,
    input  logic [CHANNELS-1:0] tx_ready,
    input  logic [CHANNELS-1:0] tx_vc_ready,
    output logic                busy,
    output logic [15:0]         pkt_count
);

    localparam int HDR_W = 2 * ID_X_W + 2 * ID_Y_W + LEN_W;
    localparam int PAD_W = FLIT_W - 2 - HDR_W;
    localparam int VC_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic [1:0] {IDLE, VC_SEL, HEAD, BODY} state_t;

    state_t              state_q, state_d;
    logic [ID_X_W-1:0]   dx_q, dx_d, sx_q, sx_d;
    logic [ID_Y_W-1:0]   dy_q, dy_d, sy_q, sy_d;
    logic [LEN_W-1:0]    len_q, len_d, rem_q, rem_d;
    logic [VC_W-1:0]     vc_q, vc_d;
    logic [15:0]         pkt_count_q, pkt_count_d;
    logic [FLIT_W-3:0]   head_pay;
    logic                vc_rdy;

    // Routing fields sit directly below the type field; unused LSBs stay zero.
    assign head_pay  = (FLIT_W - 2)'({dx_q, dy_q, sx_q, sy_q, len_q}) << PAD_W;
    assign vc_rdy    = tx_ready[vc_q];
    assign busy      = (state_q != IDLE);
    assign pkt_count = pkt_count_q;

    always_ff @(posedge noc_clk) begin
        if (!noc_rst_n) begin
            state_q     <= IDLE;
            dx_q        <= '0;
            dy_q        <= '0;
            sx_q        <= '0;
            sy_q        <= '0;
            len_q       <= '0;
            rem_q       <= '0;
            vc_q        <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            len_q       <= len_d;
            rem_q       <= rem_d;
            vc_q        <= vc_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        len_d       = len_q;
        rem_d       = rem_q;
        vc_d        = vc_q;
        pkt_count_d = pkt_count_q;
        msg_ready   = 1'b0;
        data_ready  = 1'b0;
        tx_valid    = '0;
        tx_flit     = '0;

        unique case (state_q)
            IDLE: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    dx_d    = msg_dest_x;
                    dy_d    = msg_dest_y;
                    sx_d    = id_x;
                    sy_d    = id_y;
                    len_d   = msg_len;
                    state_d = VC_SEL;
                end
            end
            VC_SEL: begin
                // Descending scan so the lowest free index wins.
                for (int i = CHANNELS - 1; i >= 0; i--) begin
                    if (tx_vc_ready[i]) begin
                        vc_d    = VC_W'(i);
                        state_d = HEAD;
                    end
                end
            end
            HEAD: begin
                tx_valid[vc_q] = 1'b1;
                tx_flit = {(len_q == '0) ? T_SINGLE : T_HEAD, head_pay};
                if (vc_rdy) begin
                    if (len_q == '0) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        state_d     = IDLE;
                    end else begin
                        rem_d   = len_q;
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                tx_valid[vc_q] = data_valid;
                data_ready     = vc_rdy;
                tx_flit = {(rem_q == LEN_W'(1)) ? T_TAIL : T_BODY, data};
                if (data_valid && vc_rdy) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_noc_local_injector.sv
// Directed bench: an expected-flit queue built from each message drives a per-cycle
// monitor, with literal checks on head/tail encodings and the packet counter.
module tb_noc_local_injector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  id_x, id_y;
    logic        msg_valid, msg_ready;
    logic [3:0]  msg_dest_x, msg_dest_y, msg_len;
    logic        data_valid, data_ready;
    logic [31:0] data;
    logic [1:0]  tx_valid, tx_ready, tx_vc_ready;
    logic [33:0] tx_flit;
    logic        busy;
    logic [15:0] pkt_count;

    always #5 clk = ~clk;

    noc_local_injector dut (
        .noc_clk(clk), .noc_rst_n(rst_n), .id_x(id_x), .id_y(id_y),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_dest_x(msg_dest_x), .msg_dest_y(msg_dest_y), .msg_len(msg_len),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .tx_valid(tx_valid), .tx_flit(tx_flit), .tx_ready(tx_ready),
        .tx_vc_ready(tx_vc_ready), .busy(busy), .pkt_count(pkt_count)
    );

    typedef struct { int vc; logic [33:0] flit; } exp_t;
    exp_t        exp_q[$];
    int          vectors = 0;
    int          errors  = 0;
    logic [15:0] mcnt = '0;
    logic [33:0] last_flit = '0;
    int          last_vc = -1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [31:0] pay(input logic [31:0] base, input int k);
        return base + 32'(k) * 32'h1111_1111;
    endfunction

    // Monitor: samples 4 time units after each falling edge, i.e. just before the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                exp_q.delete();
                mcnt = '0;
            end else begin
                chk("busy_vs_msg_ready", busy, !msg_ready);
                chk("pkt_count", pkt_count, mcnt);
                chk("valid_onehot", $countones(tx_valid) <= 1, 1);
                if (|(tx_valid & tx_ready)) begin
                    int   vc;
                    exp_t e;
                    vc = tx_valid[1] ? 1 : 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_flit", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("flit_vc", vc, e.vc);
                        chk("flit_data", tx_flit, e.flit);
                        if (e.flit[33]) mcnt = mcnt + 16'd1;
                    end
                    last_flit = tx_flit;
                    last_vc   = vc;
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        #4;
        while (!msg_ready && n < 100) begin @(negedge clk); #4; n++; end
        chk("idle_timeout", n < 100, 1);
        @(negedge clk);
    endtask

    // Called on a falling edge. abort>=0 stops feeding payload before index abort and resets.
    task automatic send_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] len,
                            input logic [31:0] base, input int vc, input bit bp_head,
                            input bit bp_body, input bit nofree, input int abort);
        exp_t        e;
        int          n;
        logic [33:0] hf;
        e.vc   = vc;
        e.flit = {(len == 0) ? 2'b11 : 2'b01, dx, dy, id_x, id_y, len, 12'h000};
        exp_q.push_back(e);
        for (int k = 0; k < int'(len); k++) begin
            e.flit = {(k == int'(len) - 1) ? 2'b10 : 2'b00, pay(base, k)};
            exp_q.push_back(e);
        end
        if (bp_head) tx_ready = 2'b00;
        msg_valid = 1'b1; msg_dest_x = dx; msg_dest_y = dy; msg_len = len;
        n = 0;
        #4;
        while (!msg_ready && n < 100) begin @(negedge clk); #4; n++; end
        chk("accept_timeout", n < 100, 1);
        @(negedge clk);
        msg_valid = 1'b0;
        if (nofree) begin
            repeat (5) begin
                #4;
                chk("vcsel_busy", busy, 1);
                chk("vcsel_no_valid", tx_valid, 2'b00);
                @(negedge clk);
            end
            tx_vc_ready = 2'b01;
        end
        if (bp_head) begin
            n = 0;
            #4;
            while (tx_valid == 2'b00 && n < 100) begin @(negedge clk); #4; n++; end
            chk("head_timeout", n < 100, 1);
            hf = tx_flit;
            chk("head_held_flit0", hf, {(len == 0) ? 2'b11 : 2'b01, dx, dy, id_x, id_y, len, 12'h000});
            repeat (4) begin
                @(negedge clk); #4;
                chk("head_hold_flit", tx_flit, hf);
                chk("head_hold_valid", tx_valid != 2'b00, 1);
            end
            @(negedge clk);
            tx_ready = 2'b11;
        end
        for (int k = 0; k < int'(len); k++) begin
            if (k == abort) break;
            data_valid = 1'b1;
            data = pay(base, k);
            if (bp_body && k == 1) begin
                tx_ready = 2'b00;
                repeat (4) begin
                    #4;
                    chk("body_hold_ready", data_ready, 0);
                    chk("body_hold_flit", tx_flit,
                        {(k == int'(len) - 1) ? 2'b10 : 2'b00, pay(base, k)});
                    @(negedge clk);
                end
                tx_ready = 2'b11;
            end
            n = 0;
            #4;
            while (!data_ready && n < 100) begin @(negedge clk); #4; n++; end
            chk("data_timeout", n < 100, 1);
            @(negedge clk);
        end
        data_valid = 1'b0;
        if (abort >= 0) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            #4;
            chk("rst_mid_busy", busy, 0);
            chk("rst_mid_valid", tx_valid, 2'b00);
            chk("rst_mid_count", pkt_count, 16'd0);
            chk("rst_mid_msg_ready", msg_ready, 1);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; id_x = 4'd1; id_y = 4'd1;
        msg_valid = 1'b0; msg_dest_x = '0; msg_dest_y = '0; msg_len = '0;
        data_valid = 1'b0; data = '0; tx_ready = 2'b11; tx_vc_ready = 2'b11;
        repeat (2) @(negedge clk);
        #4;
        chk("rst_busy", busy, 0);
        chk("rst_tx_valid", tx_valid, 2'b00);
        chk("rst_tx_flit", tx_flit, 34'h0);
        chk("rst_data_ready", data_ready, 0);
        chk("rst_pkt_count", pkt_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #4;
        chk("post_rst_msg_ready", msg_ready, 1);
        chk("idle_flit_zero", tx_flit, 34'h0);
        @(negedge clk);

        // Single-flit packet on VC0.
        send_pkt(4'd3, 4'd2, 4'd0, 32'h0, 0, 0, 0, 0, -1);
        wait_idle();
        chk("single_flit", last_flit, 34'h3_3211_0000);
        chk("single_vc", last_vc, 0);
        chk("single_count", pkt_count, 16'd1);

        // Three payloads, only VC1 free.
        tx_vc_ready = 2'b10;
        send_pkt(4'd5, 4'd6, 4'd3, 32'hAAAA_AAAA, 1, 0, 0, 0, -1);
        wait_idle();
        chk("three_tail_flit", last_flit, 34'h2_CCCC_CCCC);
        chk("three_vc", last_vc, 1);
        chk("three_count", pkt_count, 16'd2);

        // Backpressure during head and body.
        tx_vc_ready = 2'b11;
        send_pkt(4'd2, 4'd7, 4'd3, 32'h1234_5678, 0, 1, 1, 0, -1);
        wait_idle();
        chk("bp_count", pkt_count, 16'd3);

        // No VC free for 5 cycles, then VC0.
        tx_vc_ready = 2'b00;
        send_pkt(4'd9, 4'd4, 4'd2, 32'h0BAD_F00D, 0, 0, 0, 1, -1);
        wait_idle();
        chk("nofree_vc", last_vc, 0);
        chk("nofree_count", pkt_count, 16'd4);

        // Length sweep including the maximum.
        tx_vc_ready = 2'b11;
        send_pkt(4'd1, 4'd15, 4'd1, 32'h5555_0000, 0, 0, 0, 0, -1);
        wait_idle();
        chk("len1_tail", last_flit, 34'h2_5555_0000);
        send_pkt(4'd15, 4'd0, 4'd15, 32'h0000_0001, 0, 0, 0, 0, -1);
        wait_idle();
        chk("len15_count", pkt_count, 16'd6);

        // Reset after 2 of 5 payloads, then a clean single-flit packet.
        send_pkt(4'd6, 4'd6, 4'd5, 32'h7000_0000, 0, 0, 0, 0, 2);
        send_pkt(4'd3, 4'd3, 4'd0, 32'h0, 0, 0, 0, 0, -1);
        wait_idle();
        chk("after_rst_count", pkt_count, 16'd1);
        chk("after_rst_flit", last_flit, 34'h3_3311_0000);

        // Counter wrap: preload near the top instead of streaming 65k packets.
        force dut.pkt_count_q = 16'hFFFE;
        mcnt = 16'hFFFE;
        @(negedge clk);
        release dut.pkt_count_q;
        @(negedge clk);
        send_pkt(4'd2, 4'd2, 4'd0, 32'h0, 0, 0, 0, 0, -1);
        wait_idle();
        chk("wrap_ffff", pkt_count, 16'hFFFF);
        send_pkt(4'd2, 4'd2, 4'd0, 32'h0, 0, 0, 0, 0, -1);
        wait_idle();
        chk("wrap_zero", pkt_count, 16'h0000);
        chk("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
